// File: rtl/nios_accelerometer_avg_filter.sv
// Avalon-MM accelerometer input port: per-channel moving average over 2^LOG2_DEPTH
// signed samples, with CTRL/STATUS registers, raw bypass and a new-data interrupt.
module nios_accelerometer_avg_filter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 3,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   address,
  input  logic                         write,
  input  logic [31:0]                  writedata,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_port,
  input  logic                         sample_valid,
  output logic [31:0]                  readdata,
  output logic                         irq
);

  localparam int D  = 1 << LOG2_DEPTH;
  localparam int SW = DATA_WIDTH + LOG2_DEPTH;
  localparam int PW = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int FW = LOG2_DEPTH + 1;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [SW-1:0]         sum_t;

  function automatic logic [31:0] sext32(input sample_t x);
    return 32'(x);
  endfunction

  logic          enable_q, enable_d;
  logic          bypass_q, bypass_d;
  logic          irq_en_q, irq_en_d;
  logic          data_ready_q, data_ready_d;
  logic          overrun_q, overrun_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          irq_q, irq_d;
  sample_t       buf_q [NUM_CH][D];
  sample_t       buf_d [NUM_CH][D];
  sum_t          sum_q [NUM_CH];
  sum_t          sum_d [NUM_CH];
  sample_t       raw_q [NUM_CH];
  sample_t       raw_d [NUM_CH];

  logic          ctrl_wr_s, stat_wr_s, clear_s, accept_s, window_full_s;
  sample_t       new_s    [NUM_CH];
  sum_t          shift_s  [NUM_CH];
  sample_t       avg_s    [NUM_CH];
  logic [31:0]   ch_val_s [NUM_CH];

  // Bus decode, accept qualification and per-channel result values.
  always_comb begin
    ctrl_wr_s     = write && (address == 3'd0);
    stat_wr_s     = write && (address == 3'd1);
    clear_s       = ctrl_wr_s && writedata[3];
    accept_s      = sample_valid && enable_q && !clear_s;
    window_full_s = (fill_q == FW'(D));
    for (int i = 0; i < NUM_CH; i++) begin
      new_s[i]    = in_port[i*DATA_WIDTH +: DATA_WIDTH];
      shift_s[i]  = sum_q[i] >>> LOG2_DEPTH;
      avg_s[i]    = shift_s[i][DATA_WIDTH-1:0];
      ch_val_s[i] = bypass_q ? sext32(raw_q[i]) : sext32(avg_s[i]);
    end
  end

  // Control bits and sticky status flags; on a coincident accept the set beats W1C.
  always_comb begin
    enable_d     = ctrl_wr_s ? writedata[0] : enable_q;
    bypass_d     = ctrl_wr_s ? writedata[1] : bypass_q;
    irq_en_d     = ctrl_wr_s ? writedata[2] : irq_en_q;
    data_ready_d = clear_s ? 1'b0
                 : (accept_s | (data_ready_q & ~(stat_wr_s & writedata[0])));
    overrun_d    = clear_s ? 1'b0
                 : ((accept_s & data_ready_q) | (overrun_q & ~(stat_wr_s & writedata[2])));
    irq_d        = data_ready_d & irq_en_d;
  end

  // Ring buffers, running sums and the shared write pointer / fill counter.
  always_comb begin
    wptr_d = wptr_q;
    fill_d = fill_q;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_d[i] = sum_q[i];
      raw_d[i] = raw_q[i];
      for (int j = 0; j < D; j++) begin
        buf_d[i][j] = buf_q[i][j];
      end
    end
    if (clear_s) begin
      wptr_d = '0;
      fill_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sum_d[i] = '0;
        raw_d[i] = '0;
        for (int j = 0; j < D; j++) begin
          buf_d[i][j] = '0;
        end
      end
    end else if (accept_s) begin
      // The oldest entry leaves the sum as the new sample replaces it in the ring.
      for (int i = 0; i < NUM_CH; i++) begin
        sum_d[i]         = sum_q[i] + SW'(new_s[i]) - SW'(buf_q[i][wptr_q]);
        buf_d[i][wptr_q] = new_s[i];
        raw_d[i]         = new_s[i];
      end
      wptr_d = (wptr_q == PW'(D - 1)) ? PW'(0) : (wptr_q + PW'(1));
      fill_d = window_full_s ? fill_q : (fill_q + FW'(1));
    end else begin
      wptr_d = wptr_q;
      fill_d = fill_q;
    end
  end

  // Read mux for the address presented this cycle.
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      3'd0:    readdata_d = {29'd0, irq_en_q, bypass_q, enable_q};
      3'd1:    readdata_d = {29'd0, overrun_q, window_full_s, data_ready_q};
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          readdata_d = (address == 3'(i + 2)) ? ch_val_s[i] : readdata_d;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q     <= 1'b0;
      bypass_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      wptr_q       <= '0;
      fill_q       <= '0;
      readdata_q   <= 32'd0;
      irq_q        <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i] <= '0;
        raw_q[i] <= '0;
        for (int j = 0; j < D; j++) begin
          buf_q[i][j] <= '0;
        end
      end
    end else begin
      enable_q     <= enable_d;
      bypass_q     <= bypass_d;
      irq_en_q     <= irq_en_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      wptr_q       <= wptr_d;
      fill_q       <= fill_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i] <= sum_d[i];
        raw_q[i] <= raw_d[i];
        for (int j = 0; j < D; j++) begin
          buf_q[i][j] <= buf_d[i][j];
        end
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
